absorb_controller: RTL and testbench

ABSORB_CONTROLLER -- requirements
Module: absorb_controller

---
 rtl/keccak_pkg.sv | 23 ++
 rtl/absorb_controller.sv | 157 +++++++++++++++
 tb/tb_absorb_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE constants and types for the absorb-phase control logic.
package keccak_pkg;

  localparam int w            = 64;
  localparam int w_byte_size  = 8;
  localparam int w_byte_width = 4;

  // Rate in 64-bit lanes: SHAKE128 uses 1344 bits, SHAKE256 uses 1088 bits.
  localparam logic [4:0] RATE_WORDS_128 = 5'd21;
  localparam logic [4:0] RATE_WORDS_256 = 5'd17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ABSORB    = 2'd1,
    PERM_WAIT = 2'd2,
    DONE      = 2'd3
  } absorb_state_t;

  function automatic logic [4:0] rate_for_mode(input logic shake_mode);
    return shake_mode ? RATE_WORDS_256 : RATE_WORDS_128;
  endfunction

endpackage

// File: rtl/absorb_controller.sv
// Sequences message words into rate-sized blocks, drives padding controls and permutation requests.
// Optional block counter output enabled by defining ABSORB_BLOCK_COUNT_EN.
module absorb_controller
  import keccak_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             msg_len,
  input  logic                    shake_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [w-1:0]            in_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [w-1:0]            word_data,
  output logic [4:0]              word_idx,
  output logic [w_byte_width-1:0] pad_valid_bytes,
  output logic                    pad_enable,
  output logic                    pad_last_word,
  output logic                    pad_reset,
  output logic                    perm_start,
  input  logic                    perm_done,
  output logic                    busy,
  output logic                    absorb_done
`ifdef ABSORB_BLOCK_COUNT_EN
  ,
  output logic [15:0]             block_count
`endif
);

  absorb_state_t state_reg, state_next;
  logic [31:0]   remaining_reg, remaining_next;
  logic [4:0]    rate_reg, rate_next;
  logic [4:0]    word_idx_reg, word_idx_next;
  logic          final_flag_reg, final_flag_next;
  logic          perm_start_reg, perm_start_next;
  logic          pad_reset_reg, pad_reset_next;
  logic          has_data;
  logic          transfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      rate_reg       <= '0;
      word_idx_reg   <= '0;
      final_flag_reg <= 1'b0;
      perm_start_reg <= 1'b0;
      pad_reset_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      rate_reg       <= rate_next;
      word_idx_reg   <= word_idx_next;
      final_flag_reg <= final_flag_next;
      perm_start_reg <= perm_start_next;
      pad_reset_reg  <= pad_reset_next;
    end
  end

  assign has_data = (remaining_reg != 32'd0);

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    rate_next       = rate_reg;
    word_idx_next   = word_idx_reg;
    final_flag_next = final_flag_reg;
    perm_start_next = 1'b0;
    pad_reset_next  = 1'b0;
    in_ready        = 1'b0;
    word_valid      = 1'b0;
    word_data       = '0;
    pad_valid_bytes = '0;
    pad_enable      = 1'b0;
    pad_last_word   = 1'b0;
    absorb_done     = 1'b0;
    transfer        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next  = msg_len;
          rate_next       = rate_for_mode(shake_mode);
          word_idx_next   = '0;
          final_flag_next = 1'b0;
          pad_reset_next  = 1'b1;
          state_next      = ABSORB;
        end
      end

      ABSORB: begin
        if (has_data) begin
          in_ready   = word_ready;
          word_valid = in_valid;
          word_data  = in_data;
          pad_valid_bytes = (remaining_reg >= 32'(w_byte_size)) ? w_byte_width'(w_byte_size)
                                                                : remaining_reg[w_byte_width-1:0];
        end else begin
          // Message exhausted: emit zero words so the padder can fill the rest of the block.
          word_valid = 1'b1;
        end
        pad_enable    = word_valid && (remaining_reg < 32'(w_byte_size));
        pad_last_word = word_valid && (word_idx_reg == rate_reg - 5'd1);
        transfer      = word_valid && word_ready;

        if (transfer) begin
          remaining_next = remaining_reg - 32'(pad_valid_bytes);
          if (pad_enable && (pad_valid_bytes < w_byte_width'(w_byte_size)))
            final_flag_next = 1'b1;
          if (pad_last_word) begin
            word_idx_next   = '0;
            perm_start_next = 1'b1;
            state_next      = PERM_WAIT;
          end else begin
            word_idx_next = word_idx_reg + 5'd1;
          end
        end
      end

      PERM_WAIT: begin
        if (perm_done)
          state_next = final_flag_reg ? DONE : ABSORB;
      end

      DONE: begin
        absorb_done = 1'b1;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign word_idx   = word_idx_reg;
  assign perm_start = perm_start_reg;
  assign pad_reset  = pad_reset_reg;
  assign busy       = (state_reg != IDLE);

`ifdef ABSORB_BLOCK_COUNT_EN
  logic [15:0] block_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_count_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      block_count_reg <= '0;
    end else if (perm_start_reg && (block_count_reg != 16'hFFFF)) begin
      block_count_reg <= block_count_reg + 16'd1;
    end
  end

  assign block_count = block_count_reg;
`endif

endmodule

// File: tb/tb_absorb_controller.sv
// Scoreboard bench for absorb_controller: expected words queued at stimulus time, popped on each transfer.
module tb_absorb_controller;
  import keccak_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [31:0]             msg_len;
  logic                    shake_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [w-1:0]            in_data;
  logic                    word_valid;
  logic                    word_ready;
  logic [w-1:0]            word_data;
  logic [4:0]              word_idx;
  logic [w_byte_width-1:0] pad_valid_bytes;
  logic                    pad_enable;
  logic                    pad_last_word;
  logic                    pad_reset;
  logic                    perm_start;
  logic                    perm_done;
  logic                    busy;
  logic                    absorb_done;
`ifdef ABSORB_BLOCK_COUNT_EN
  logic [15:0]             block_count;
`endif

  always #5 clk = ~clk;

  absorb_controller dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .msg_len         (msg_len),
    .shake_mode      (shake_mode),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .word_data       (word_data),
    .word_idx        (word_idx),
    .pad_valid_bytes (pad_valid_bytes),
    .pad_enable      (pad_enable),
    .pad_last_word   (pad_last_word),
    .pad_reset       (pad_reset),
    .perm_start      (perm_start),
    .perm_done       (perm_done),
    .busy            (busy),
    .absorb_done     (absorb_done)
`ifdef ABSORB_BLOCK_COUNT_EN
    ,
    .block_count     (block_count)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  idx;
    logic [3:0]  vbytes;
    logic        pad_en;
    logic        last;
  } exp_word_t;

  exp_word_t   exp_q[$];
  logic [63:0] in_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_busy"}, busy, 0);
    check_value({tag, "_word_valid"}, word_valid, 0);
    check_value({tag, "_in_ready"}, in_ready, 0);
    check_value({tag, "_perm_start"}, perm_start, 0);
    check_value({tag, "_absorb_done"}, absorb_done, 0);
    check_value({tag, "_pad_reset"}, pad_reset, 0);
    check_value({tag, "_pad_enable"}, pad_enable, 0);
    check_value({tag, "_word_idx"}, word_idx, 0);
    check_value({tag, "_word_data"}, word_data, 0);
`ifdef ABSORB_BLOCK_COUNT_EN
    check_value({tag, "_block_count"}, block_count, 0);
`endif
  endtask

  task automatic run_msg(input logic mode, input int len, input int stall_pct, input bit poke_start);
    int        rate, blocks, rem, perms, pd_count, words_seen;
    bit        done, stalled_prev;
    logic [63:0] hold_data;
    logic [4:0]  hold_idx;
    logic [3:0]  hold_vb;
    exp_word_t e;

    rate   = mode ? 17 : 21;
    blocks = len / (8 * rate) + 1;
    for (int k = 0; k < blocks * rate; k++) begin
      rem = len - 8 * k;
      if (rem < 0) rem = 0;
      e.vbytes = 4'((rem >= 8) ? 8 : rem);
      e.pad_en = (rem < 8);
      e.idx    = 5'(k % rate);
      e.last   = ((k % rate) == rate - 1);
      if (rem > 0) begin
        e.data = {$urandom, $urandom};
        in_q.push_back(e.data);
      end else begin
        e.data = '0;
      end
      exp_q.push_back(e);
    end

    @(negedge clk);
    start = 1'b1; msg_len = 32'(len); shake_mode = mode;
    word_ready = 1'b0; in_valid = 1'b0; perm_done = 1'b0;
    @(negedge clk);
    start = 1'b0; msg_len = $urandom; shake_mode = ~mode;
    #1;
    check_value("pad_reset_pulse", pad_reset, 1);
    check_value("busy_after_start", busy, 1);

    perms = 0; pd_count = 0; done = 0; stalled_prev = 0; words_seen = 0;
    hold_data = '0; hold_idx = '0; hold_vb = '0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      start      = poke_start && (cyc == 4);
      msg_len    = start ? 32'd99 : msg_len;
      perm_done  = (pd_count == 1);
      if (pd_count > 0) pd_count--;
      word_ready = ($urandom_range(99) >= stall_pct);
      in_valid   = (in_q.size() > 0);
      in_data    = (in_q.size() > 0) ? in_q[0] : {$urandom, $urandom};
      #1;
      if (stalled_prev) begin
        check_value("hold_valid", word_valid, 1);
        check_value("hold_idx", word_idx, hold_idx);
        check_value("hold_vbytes", pad_valid_bytes, hold_vb);
        check_value("hold_data", word_data, hold_data);
      end
      stalled_prev = word_valid && !word_ready;
      hold_data = word_data; hold_idx = word_idx; hold_vb = pad_valid_bytes;

      if (word_valid && word_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check_value("sb_extra_word", 64'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check_value("word_data", word_data, e.data);
          check_value("word_idx", word_idx, e.idx);
          check_value("pad_valid_bytes", pad_valid_bytes, e.vbytes);
          check_value("pad_enable", pad_enable, e.pad_en);
          check_value("pad_last_word", pad_last_word, e.last);
        end
      end
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (perm_start) begin
        perms++;
        pd_count = 3;
      end
      if (absorb_done) done = 1;
    end

    check_value("absorb_done_seen", done, 1);
    check_value("perm_start_count", 64'(perms), 64'(blocks));
    check_value("sb_left_over", 64'(exp_q.size()), 0);
    check_value("input_left_over", 64'(in_q.size()), 0);
`ifdef ABSORB_BLOCK_COUNT_EN
    check_value("block_count", block_count, 64'(blocks));
`endif
    @(negedge clk);
    #1;
    check_value("busy_after_done", busy, 0);
    check_value("absorb_done_one_cycle", absorb_done, 0);
    $display("msg mode=%0d len=%0d words=%0d perms=%0d expected_blocks=%0d", mode, len, words_seen, perms, blocks);
    exp_q.delete();
    in_q.delete();
  endtask

  task automatic reset_in_perm_wait();
    bit seen;
    bit activity;
    @(negedge clk);
    start = 1'b1; msg_len = 32'd0; shake_mode = 1'b0;
    word_ready = 1'b1; in_valid = 1'b0; perm_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      #1;
      if (perm_start) seen = 1;
    end
    check_value("rst_test_perm_start_seen", seen, 1);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_perm_wait");
    @(negedge clk);
    rst = 1'b1;
    perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
    activity = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      #1;
      activity = activity | perm_start | absorb_done | busy | word_valid;
    end
    check_value("post_rst_activity", activity, 0);
    $display("reset in PERM_WAIT: activity after late perm_done=%0d", activity);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; msg_len = '0; shake_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; word_ready = 1'b0; perm_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    run_msg(1'b0, 0,   0,  1'b0);
    run_msg(1'b0, 13,  30, 1'b0);
    run_msg(1'b1, 136, 0,  1'b0);
    run_msg(1'b0, 167, 0,  1'b0);
    run_msg(1'b1, 300, 40, 1'b1);
    run_msg(1'b0, 168, 20, 1'b1);
    reset_in_perm_wait();
    run_msg(1'b1, 5,   50, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
